// File: rtl/store_rmw_ctrl.sv
// Read-modify-write sequencer for byte/halfword stores into a word-only data memory.
// Full-word stores write directly; misaligned or unknown stores are rejected without touching memory.

`ifndef STORE_SB
`define STORE_SB 2'b00
`endif
`ifndef STORE_SH
`define STORE_SH 2'b01
`endif
`ifndef STORE_SW
`define STORE_SW 2'b10
`endif

module store_rmw_ctrl #(
   parameter int RD_LAT = 1,
   parameter int ADDR_W = 32
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [1:0]        req_op,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ren,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wen,
   output logic [31:0]       mem_wdata,
   output logic              done,
   output logic              misalign_err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [1:0]  op_q;
   logic [1:0]  shift_q;
   logic [15:0] wdata_q;
   logic        misaligned;
   logic [31:0] merged;

   always_comb begin
      misaligned = 1'b0;
      case (req_op)
         `STORE_SB: misaligned = 1'b0;
         `STORE_SH: misaligned = req_addr[0];
         `STORE_SW: misaligned = (req_addr[1:0] != 2'b00);
         default:   misaligned = 1'b1;
      endcase
   end

   // Only SB and SH ever reach the merge, so anything that is not SB is a halfword.
   always_comb begin
      merged = mem_rdata;
      if (op_q == `STORE_SB) begin
         merged[{shift_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{shift_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         op_q         <= '0;
         shift_q      <= '0;
         wdata_q      <= '0;
         req_ready    <= 1'b1;
         mem_addr     <= '0;
         mem_ren      <= 1'b0;
         mem_wen      <= 1'b0;
         mem_wdata    <= '0;
         done         <= 1'b0;
         misalign_err <= 1'b0;
         busy         <= 1'b0;
      end else begin
         mem_ren      <= 1'b0;
         mem_wen      <= 1'b0;
         done         <= 1'b0;
         misalign_err <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  op_q    <= req_op;
                  shift_q <= req_addr[1:0];
                  wdata_q <= req_wdata[15:0];
                  if (misaligned) begin
                     misalign_err <= 1'b1;
                  end else begin
                     mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     busy      <= 1'b1;
                     req_ready <= 1'b0;
                     if (req_op == `STORE_SW) begin
                        state     <= WRITE;
                        mem_wen   <= 1'b1;
                        done      <= 1'b1;
                        mem_wdata <= req_wdata;
                     end else begin
                        state   <= READ;
                        mem_ren <= 1'b1;
                     end
                  end
               end
            end
            READ: begin
               state <= WAIT;
               cnt   <= 3'(RD_LAT);
            end
            // Read data is valid in the cycle where the count has run down to one.
            WAIT: begin
               if (cnt == 3'd1) begin
                  mem_wdata <= merged;
                  mem_wen   <= 1'b1;
                  done      <= 1'b1;
                  cnt       <= '0;
                  state     <= WRITE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            WRITE: begin
               state     <= IDLE;
               mem_addr  <= '0;
               mem_wdata <= '0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: two instances (read latency 1 and 3), a transaction-level
// schedule of expected outputs per cycle, and a memory responder that returns stale data off-cycle.
`timescale 1ns/1ps

`ifndef STORE_SB
`define STORE_SB 2'b00
`endif
`ifndef STORE_SH
`define STORE_SH 2'b01
`endif
`ifndef STORE_SW
`define STORE_SW 2'b10
`endif

module tb_store_rmw_ctrl;

   localparam int ADDR_W = 32;
   localparam int LAT0   = 1;
   localparam int LAT1   = 3;

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic        done;
      logic        err;
      logic        busy;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic        req_valid    [2];
   logic        req_ready    [2];
   logic [31:0] req_addr     [2];
   logic [31:0] req_wdata    [2];
   logic [1:0]  req_op       [2];
   logic [31:0] mem_addr     [2];
   logic        mem_ren      [2];
   logic [31:0] mem_rdata    [2];
   logic        mem_wen      [2];
   logic [31:0] mem_wdata    [2];
   logic        done         [2];
   logic        misalign_err [2];
   logic        busy         [2];

   longint      cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   exp_t        sched     [longint];
   logic [31:0] model_mem [longint];
   logic [31:0] env_mem   [longint];
   logic [31:0] pending   [longint];

   longint      free_cyc      [2];
   longint      acc_cyc       [2];
   logic [31:0] last_exp_wdata[2];
   logic [31:0] saved_word    [2];
   logic [31:0] saved_val     [2];
   longint      last_wen_cyc  [2];
   logic [31:0] last_wen_data [2];
   int          ren_count     [2];
   int          wen_count     [2];
   int          err_count     [2];

   always #5 clk = ~clk;

   store_rmw_ctrl #(.RD_LAT(LAT0), .ADDR_W(ADDR_W)) u_lat1 (
      .cpu_clk(clk), .cpu_rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .req_op(req_op[0]),
      .mem_addr(mem_addr[0]), .mem_ren(mem_ren[0]), .mem_rdata(mem_rdata[0]),
      .mem_wen(mem_wen[0]), .mem_wdata(mem_wdata[0]),
      .done(done[0]), .misalign_err(misalign_err[0]), .busy(busy[0])
   );

   store_rmw_ctrl #(.RD_LAT(LAT1), .ADDR_W(ADDR_W)) u_lat3 (
      .cpu_clk(clk), .cpu_rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .req_op(req_op[1]),
      .mem_addr(mem_addr[1]), .mem_ren(mem_ren[1]), .mem_rdata(mem_rdata[1]),
      .mem_wen(mem_wen[1]), .mem_wdata(mem_wdata[1]),
      .done(done[1]), .misalign_err(misalign_err[1]), .busy(busy[1])
   );

   function automatic int lat(input int lane);
      return (lane == 0) ? LAT0 : LAT1;
   endfunction

   function automatic longint skey(input int lane, input longint c);
      return (longint'(lane) << 40) + c;
   endfunction

   function automatic longint mkey(input int lane, input logic [31:0] a);
      return (longint'(lane) << 40) + longint'({32'h0, a});
   endfunction

   function automatic bit is_legal(input logic [1:0] op, input logic [31:0] a);
      if (op == `STORE_SB) return 1'b1;
      if (op == `STORE_SH) return (a[0] == 1'b0);
      if (op == `STORE_SW) return (a[1:0] == 2'b00);
      return 1'b0;
   endfunction

   // Byte-array view of a store: replace one, two or four bytes starting at the offset.
   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] op,
                                               input int off, input logic [31:0] src);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
      if (op == `STORE_SB) begin
         b[off] = src[7:0];
      end else if (op == `STORE_SH) begin
         b[off]     = src[7:0];
         b[off + 1] = src[15:8];
      end else begin
         for (int i = 0; i < 4; i++) b[i] = src[8*i +: 8];
      end
      return {b[3], b[2], b[1], b[0]};
   endfunction

   function automatic logic [31:0] model_get(input longint k);
      return model_mem.exists(k) ? model_mem[k] : 32'h0;
   endfunction

   task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_output(input int l);
      exp_t e;
      logic ok;
      e = '0;
      if (sched.exists(skey(l, cyc))) e = sched[skey(l, cyc)];
      ok = (mem_ren[l] === e.ren) && (mem_wen[l] === e.wen) && (done[l] === e.done) &&
           (misalign_err[l] === e.err) && (busy[l] === e.busy) && (req_ready[l] === ~e.busy) &&
           (mem_addr[l] === e.addr) && (mem_wdata[l] === e.wdata);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("[TB] FAIL outputs lane%0d cyc%0d: got ren=%b wen=%b done=%b err=%b busy=%b rdy=%b addr=%h wdata=%h, expected ren=%b wen=%b done=%b err=%b busy=%b rdy=%b addr=%h wdata=%h",
                  l, cyc, mem_ren[l], mem_wen[l], done[l], misalign_err[l], busy[l], req_ready[l],
                  mem_addr[l], mem_wdata[l], e.ren, e.wen, e.done, e.err, e.busy, ~e.busy, e.addr, e.wdata);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle comparison plus the memory side of the environment.
   always @(negedge clk) begin
      if (cyc > 0) begin
         for (int l = 0; l < 2; l++) begin
            check_output(l);
            if (mem_ren[l] === 1'b1) begin
               ren_count[l]++;
               pending[skey(l, cyc + lat(l))] = env_mem.exists(mkey(l, mem_addr[l])) ?
                                                env_mem[mkey(l, mem_addr[l])] : 32'h0;
            end
            if (mem_wen[l] === 1'b1) begin
               wen_count[l]++;
               last_wen_cyc[l]  = cyc;
               last_wen_data[l] = mem_wdata[l];
               env_mem[mkey(l, mem_addr[l])] = mem_wdata[l];
            end
            if (misalign_err[l] === 1'b1) err_count[l]++;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int l = 0; l < 2; l++) begin
         if (pending.exists(skey(l, cyc))) begin
            mem_rdata[l] = pending[skey(l, cyc)];
            pending.delete(skey(l, cyc));
         end else begin
            mem_rdata[l] = $urandom;
         end
      end
   end

   task automatic wait_until(input longint target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic preload(input int lane, input logic [31:0] a, input logic [31:0] v);
      model_mem[mkey(lane, a)] = v;
      env_mem[mkey(lane, a)]   = v;
   endtask

   // Called at a negedge; presents one request and schedules everything it must cause.
   task automatic apply_stimulus(input int lane, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] wd);
      longint      c;
      exp_t        e;
      logic [31:0] word;
      logic [31:0] nv;
      wait_until(free_cyc[lane]);
      c = cyc;
      acc_cyc[lane]   = c;
      req_valid[lane] = 1'b1;
      req_op[lane]    = op;
      req_addr[lane]  = a;
      req_wdata[lane] = wd;
      word = {a[31:2], 2'b00};
      if (!is_legal(op, a)) begin
         e = '0;
         e.err = 1'b1;
         sched[skey(lane, c + 1)] = e;
         free_cyc[lane] = c + 1;
      end else begin
         saved_word[lane] = word;
         saved_val[lane]  = model_get(mkey(lane, word));
         nv = model_store(saved_val[lane], op, int'(a[1:0]), wd);
         last_exp_wdata[lane] = nv;
         model_mem[mkey(lane, word)] = nv;
         if (op == `STORE_SW) begin
            e = '0;
            e.wen = 1'b1; e.done = 1'b1; e.busy = 1'b1; e.addr = word; e.wdata = nv;
            sched[skey(lane, c + 1)] = e;
            free_cyc[lane] = c + 2;
         end else begin
            for (int k = 1; k <= 1 + lat(lane); k++) begin
               e = '0;
               e.busy = 1'b1; e.addr = word; e.ren = (k == 1);
               sched[skey(lane, c + k)] = e;
            end
            e = '0;
            e.wen = 1'b1; e.done = 1'b1; e.busy = 1'b1; e.addr = word; e.wdata = nv;
            sched[skey(lane, c + 2 + lat(lane))] = e;
            free_cyc[lane] = c + 3 + lat(lane);
         end
      end
      @(negedge clk);
      req_valid[lane] = 1'b0;
      req_op[lane]    = 2'($urandom_range(0, 3));
      req_addr[lane]  = $urandom;
      req_wdata[lane] = $urandom;
   endtask

   task automatic directed_store(input string name, input int lane, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_word);
      apply_stimulus(lane, op, a, wd);
      check_value({name, " model word"}, 64'(last_exp_wdata[lane]), 64'(exp_word));
      wait_until(acc_cyc[lane] + lat(lane) + 4);
      check_value({name, " write latency"}, 64'(last_wen_cyc[lane] - acc_cyc[lane]),
                  (op == `STORE_SW) ? 64'd1 : 64'(2 + lat(lane)));
      check_value({name, " written word"}, 64'(last_wen_data[lane]), 64'(exp_word));
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n_ren;
      int n_wen;
      int n_err;
      logic [1:0]  op;
      logic [31:0] a;
      for (int l = 0; l < 2; l++) begin
         req_valid[l] = 1'b0;
         req_op[l]    = 2'($urandom_range(0, 3));
         req_addr[l]  = $urandom;
         req_wdata[l] = $urandom;
         mem_rdata[l] = $urandom;
         free_cyc[l]  = 0;
         acc_cyc[l]   = 0;
         last_wen_cyc[l] = -1;
         last_wen_data[l] = '0;
         ren_count[l] = 0;
         wen_count[l] = 0;
         err_count[l] = 0;
      end

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_value("reset req_ready", 64'(req_ready[0]), 64'd1);
      check_value("reset busy", 64'(busy[1]), 64'd0);
      check_value("reset mem_addr", 64'(mem_addr[0]), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      directed_store("SW 0x100", 0, `STORE_SW, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
      check_value("SW issues no read", 64'(ren_count[0]), 64'd0);

      preload(0, 32'h200, 32'h11223344);
      directed_store("SB 0x203", 0, `STORE_SB, 32'h203, 32'h000000AA, 32'hAA223344);
      preload(0, 32'h200, 32'h11223344);
      directed_store("SB 0x200", 0, `STORE_SB, 32'h200, 32'h000000AA, 32'h112233AA);
      preload(0, 32'h200, 32'h11223344);
      directed_store("SB 0x201", 0, `STORE_SB, 32'h201, 32'h000000AA, 32'h1122AA44);
      preload(0, 32'h200, 32'h11223344);
      directed_store("SB 0x202", 0, `STORE_SB, 32'h202, 32'h000000AA, 32'h11AA3344);

      preload(0, 32'h300, 32'h11223344);
      directed_store("SH 0x302", 0, `STORE_SH, 32'h302, 32'h0000BEEF, 32'hBEEF3344);
      preload(0, 32'h300, 32'h11223344);
      directed_store("SH 0x300", 0, `STORE_SH, 32'h300, 32'h0000BEEF, 32'h1122BEEF);

      n_ren = ren_count[0];
      n_wen = wen_count[0];
      n_err = err_count[0];
      apply_stimulus(0, `STORE_SH, 32'h301, 32'h0000BEEF);
      apply_stimulus(0, `STORE_SW, 32'h302, 32'h12345678);
      apply_stimulus(0, 2'b11,     32'h304, 32'h12345678);
      repeat (3) @(negedge clk);
      check_value("misaligned err pulses", 64'(err_count[0] - n_err), 64'd3);
      check_value("misaligned no read", 64'(ren_count[0] - n_ren), 64'd0);
      check_value("misaligned no write", 64'(wen_count[0] - n_wen), 64'd0);

      preload(1, 32'h0, 32'hCAFEF00D);
      directed_store("SB lat3 0x0", 1, `STORE_SB, 32'h0, 32'h00000055, 32'hCAFEF055);

      // Abort a sub-word store while it waits for read data.
      preload(1, 32'h10, 32'h01020304);
      n_wen = wen_count[1];
      apply_stimulus(1, `STORE_SB, 32'h11, 32'h000000EE);
      wait_until(acc_cyc[1] + 2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      for (int l = 0; l < 2; l++)
         for (longint k = cyc; k < cyc + 12; k++) sched.delete(skey(l, k));
      model_mem[mkey(1, saved_word[1])] = saved_val[1];
      #1;
      check_value("abort mem_wen", 64'(mem_wen[1]), 64'd0);
      check_value("abort busy", 64'(busy[1]), 64'd0);
      check_value("abort req_ready", 64'(req_ready[1]), 64'd1);
      check_value("abort mem_addr", 64'(mem_addr[1]), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      free_cyc[0] = cyc;
      free_cyc[1] = cyc;
      @(negedge clk);
      repeat (6) @(negedge clk);
      check_value("aborted store never writes", 64'(wen_count[1] - n_wen), 64'd0);
      directed_store("SW after abort", 1, `STORE_SW, 32'h20, 32'h12345678, 32'h12345678);

      for (int l = 0; l < 2; l++) begin
         for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 32'h400 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            apply_stimulus(l, op, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      wait_until(free_cyc[0] + 4);
      wait_until(free_cyc[1] + 4);
      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
- Sequences sub-word stores into a word-wide data memory that has no byte enables. For byte and halfword stores it reads the existing word, merges in the new byte(s), then writes the whole word back.
- Sits between the execute/memory pipeline stage and the data-memory port. It also contains the byte/halfword merge logic.
- Full-word stores skip the read.
- Misaligned stores are rejected and never touch memory.

Parameters:
- RD_LAT, 1, cycles from mem_ren high to mem_rdata valid; legal range 1..4.
- ADDR_W, 32, byte-address width.

Ports:
- cpu_clk  in  1  clock; all state changes on the rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  controller can accept a request.
- req_addr  in  ADDR_W  byte address of the store.
- req_wdata  in  32  store source register; low byte or low half is used for SB/SH.
- req_op  in  2  store type, encoded with the shared defines: `STORE_SB, `STORE_SH, `STORE_SW.
- mem_addr  out  ADDR_W  word-aligned address, i.e. {addr[ADDR_W-1:2],2'b00}.
- mem_ren  out  1  one-cycle read strobe.
- mem_rdata  in  32  read data, valid RD_LAT cycles after mem_ren.
- mem_wen  out  1  one-cycle write strobe.
- mem_wdata  out  32  full word to write.
- done  out  1  one-cycle pulse: the store has completed.
- misalign_err  out  1  one-cycle pulse: the request was rejected.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE and the latency counter clears.
  - req_ready=1. mem_ren, mem_wen, done, misalign_err and busy are 0. mem_addr and mem_wdata are 0.
  - A store cut off by reset issues no further memory strobes.
- States: IDLE, READ, WAIT, WRITE.
- IDLE:
  - req_ready=1. A request is accepted on a clock edge where req_valid && req_ready; on acceptance, addr, wdata, op and shift=addr[1:0] are registered.
  - Alignment check at acceptance:
    - SH with shift[0]=1 is misaligned.
    - SW with shift!=00 is misaligned.
    - An illegal op (not one of the three defines) is treated as misaligned.
  - A misaligned request pulses misalign_err in the following cycle and stays in IDLE. No mem strobe, no done.
  - A legal SW goes to WRITE with mem_wdata=wdata.
  - A legal SB/SH goes to READ.
- READ: mem_ren=1 for exactly one cycle with mem_addr=word address. The counter loads RD_LAT. Next state is WAIT.
- WAIT:
  - The counter decrements each cycle. mem_ren=0.
  - In the cycle where the counter reaches 1, mem_rdata is sampled and merged.
  - SB: the byte at lane shift is replaced with wdata[7:0]; other lanes are kept from mem_rdata. Lane 0 is bits [7:0], lane 3 is bits [31:24].
  - SH: shift 00 replaces [15:0]; shift 10 replaces [31:16]; both use wdata[15:0].
  - The merged word is registered into the write buffer. Next state is WRITE.
- WRITE: mem_wen=1 and done=1 in the same cycle; mem_wdata is the buffered word. Next state is IDLE.
- busy=1 and req_ready=0 in READ, WAIT and WRITE. No back-to-back acceptance while busy.
- Latency (acceptance edge = end of cycle 0; RD_LAT=1):
  - SW: mem_wen in cycle 1.
  - SB/SH: mem_ren in cycle 1, sample in cycle 2, mem_wen in cycle 3.
  - General sub-word: write occurs in cycle 2+RD_LAT.
- A new request accepted in the same edge that leaves WRITE is impossible; the next acceptance is at the earliest at the end of the IDLE cycle after WRITE.
- mem_addr holds the registered word address from READ through WRITE and 0 in IDLE. mem_wdata is 0 outside WRITE.
- Inputs changing after acceptance have no effect.

Test Plan:
- Reset, then SW addr=0x100 wdata=0xDEADBEEF -> cycle 1: mem_wen=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, done=1; mem_ren never asserted.
- SB addr=0x203 wdata=0x000000AA, memory word 0x11223344 -> mem_ren with mem_addr=0x200, then mem_wen with mem_wdata=0xAA223344 in cycle 3; repeat with shift 00/01/10 -> 0x112233AA / 0x1122AA44 / 0x11AA3344.
- SH addr=0x302 wdata=0x0000BEEF, memory 0x11223344 -> mem_wdata=0xBEEF3344; SH addr=0x300 -> 0x1122BEEF.
- SH addr=0x301, then SW addr=0x302 -> misalign_err pulse one cycle after each acceptance; no mem_ren/mem_wen/done; req_ready stays 1.
- RD_LAT=3, SB addr=0x0 -> mem_wen exactly 5 cycles after acceptance; mem_rdata held stale until the sample cycle, and the merge uses the sampled value.
- cpu_rst_n asserted low while in WAIT -> all outputs 0 immediately and req_ready=1; after release, no mem_wen for the aborted store; the next SW completes normally.
